// File: rtl/rvga_types.sv
// Shared types for the memory-port arbiter: word/mask aliases, FSM state and port ids.
package rvga_types;

  typedef logic [31:0] rvga_word;
  typedef logic [3:0]  rvga_wmask;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} rvga_arb_state_e;
  typedef enum logic {e_arb_port_i, e_arb_port_d} rvga_arb_port_e;

  function automatic rvga_word word_addr(input rvga_word a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for the data port: positions store data/mask by offset,
// right-aligns load data, and flags masks that would spill past the word.
module mem_lane_align
  import rvga_types::*;
(
  input  logic [1:0] i_off,
  input  rvga_word   i_wdata,
  input  rvga_wmask  i_wmask,
  input  rvga_word   i_rdata,
  output rvga_word   o_wdata,
  output rvga_wmask  o_wmask,
  output rvga_word   o_rdata,
  output logic       o_misalign
);

  logic [7:0] w_mask_ext;

  assign w_mask_ext = {4'b0000, i_wmask} << i_off;
  assign o_wmask    = w_mask_ext[3:0];
  // Any lane pushed into the upper nibble means the access crosses the word.
  assign o_misalign = |w_mask_ext[7:4];
  assign o_wdata    = i_wdata << {i_off, 3'b000};
  assign o_rdata    = i_rdata >> {i_off, 3'b000};

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D), one transaction at a time.
// Define RVGA_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed D-over-I.
module dmem_port_arbiter
  import rvga_types::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        i_req_v_i,
  input  logic [31:0] i_addr_i,
  output logic        i_ready_o,
  output logic        i_resp_v_o,
  output logic [31:0] i_rdata_o,
  output logic        i_err_o,
  input  logic        d_req_v_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_wmask_i,
  output logic        d_ready_o,
  output logic        d_resp_v_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic        mem_req_v_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  input  logic        mem_ready_i,
  input  logic        mem_resp_v_i,
  input  logic [31:0] mem_rdata_i
);

  rvga_arb_state_e r_state;
  rvga_arb_port_e  r_owner;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]      r_off;
  logic            r_mis;

  logic       w_idle, w_wait, w_prio_d, w_acc_d, w_acc_i;
  logic       w_timeout, w_done_ok, w_done_to, w_mis_resp, w_owner_d;
  logic [1:0] w_off;
  rvga_word   w_wdata_sh, w_rdata_sh;
  rvga_wmask  w_wmask_sh;
  logic       w_misalign;

`ifdef RVGA_ARB_ROUND_ROBIN_EN
  logic r_prio_d;
  assign w_prio_d = r_prio_d;
`else
  assign w_prio_d = 1'b1;
`endif

  // Outputs are gated by reset so a transaction cut short by reset never answers.
  assign w_idle  = reset_n_i && (r_state == IDLE);
  assign w_wait  = reset_n_i && (r_state == WAIT);
  assign w_acc_d = w_idle && d_req_v_i && (w_prio_d || !i_req_v_i);
  assign w_acc_i = w_idle && i_req_v_i && !w_acc_d;

  assign i_ready_o = w_acc_i;
  assign d_ready_o = w_acc_d;

  // Live offset while arbitrating, latched offset once the access is in flight.
  assign w_off = (r_state == IDLE) ? d_addr_i[1:0] : r_off;

  mem_lane_align u_align (
    .i_off      (w_off),
    .i_wdata    (d_wdata_i),
    .i_wmask    (d_wmask_i),
    .i_rdata    (mem_rdata_i),
    .o_wdata    (w_wdata_sh),
    .o_wmask    (w_wmask_sh),
    .o_rdata    (w_rdata_sh),
    .o_misalign (w_misalign)
  );

  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign w_done_ok  = w_wait && mem_resp_v_i;
  assign w_done_to  = w_wait && !mem_resp_v_i && w_timeout;
  assign w_mis_resp = reset_n_i && (r_state == REQ) && r_mis;
  assign w_owner_d  = (r_owner == e_arb_port_d);

  assign i_resp_v_o = !w_owner_d && (w_done_ok || w_done_to);
  assign i_err_o    = !w_owner_d && w_done_to;
  assign i_rdata_o  = (!w_owner_d && w_done_ok) ? mem_rdata_i : 32'h0;

  assign d_resp_v_o = w_owner_d && (w_done_ok || w_done_to || w_mis_resp);
  assign d_err_o    = w_owner_d && (w_done_to || w_mis_resp);
  assign d_rdata_o  = (w_owner_d && w_done_ok) ? w_rdata_sh : 32'h0;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state     <= IDLE;
      r_owner     <= e_arb_port_i;
      r_cnt       <= '0;
      r_off       <= 2'b00;
      r_mis       <= 1'b0;
      mem_req_v_o <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wdata_o <= 32'h0;
      mem_wmask_o <= 4'h0;
`ifdef RVGA_ARB_ROUND_ROBIN_EN
      r_prio_d    <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc_d || w_acc_i) begin
            r_state <= REQ;
            r_cnt   <= '0;
`ifdef RVGA_ARB_ROUND_ROBIN_EN
            r_prio_d <= w_acc_i;
`endif
            if (w_acc_d) begin
              r_owner     <= e_arb_port_d;
              r_off       <= d_addr_i[1:0];
              r_mis       <= w_misalign;
              mem_req_v_o <= !w_misalign;
              mem_we_o    <= d_we_i && !w_misalign;
              mem_addr_o  <= word_addr(d_addr_i);
              mem_wdata_o <= w_wdata_sh;
              mem_wmask_o <= w_wmask_sh;
            end else begin
              r_owner     <= e_arb_port_i;
              r_off       <= 2'b00;
              r_mis       <= 1'b0;
              mem_req_v_o <= 1'b1;
              mem_we_o    <= 1'b0;
              mem_addr_o  <= word_addr(i_addr_i);
              mem_wdata_o <= 32'h0;
              mem_wmask_o <= 4'h0;
            end
          end
        end
        REQ: begin
          if (r_mis) begin
            // Misaligned access: error already reported this cycle, nothing issued.
            r_state <= IDLE;
            r_mis   <= 1'b0;
          end else if (mem_ready_i) begin
            r_state     <= WAIT;
            r_cnt       <= '0;
            mem_req_v_o <= 1'b0;
            mem_we_o    <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_resp_v_i || w_timeout) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter (TIMEOUT_CYCLES = 4).
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req_v;
  logic [31:0] i_addr;
  logic        i_ready, i_resp_v, i_err;
  logic [31:0] i_rdata;
  logic        d_req_v, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_wmask;
  logic        d_ready, d_resp_v, d_err;
  logic [31:0] d_rdata;
  logic        mem_req_v, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready, mem_resp_v;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .i_req_v_i    (i_req_v),
    .i_addr_i     (i_addr),
    .i_ready_o    (i_ready),
    .i_resp_v_o   (i_resp_v),
    .i_rdata_o    (i_rdata),
    .i_err_o      (i_err),
    .d_req_v_i    (d_req_v),
    .d_we_i       (d_we),
    .d_addr_i     (d_addr),
    .d_wdata_i    (d_wdata),
    .d_wmask_i    (d_wmask),
    .d_ready_o    (d_ready),
    .d_resp_v_o   (d_resp_v),
    .d_rdata_o    (d_rdata),
    .d_err_o      (d_err),
    .mem_req_v_o  (mem_req_v),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_wmask_o  (mem_wmask),
    .mem_ready_i  (mem_ready),
    .mem_resp_v_i (mem_resp_v),
    .mem_rdata_i  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] m);
    d_req_v = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_wmask = m;
  endtask

  logic exp_d;

  initial begin
    reset_n = 1'b0; i_req_v = 1'b0; i_addr = '0;
    d_req_v = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    mem_ready = 1'b0; mem_resp_v = 1'b0; mem_rdata = '0;
    repeat (3) step();
    reset_n = 1'b1;
    settle();
    chk("rst_mem_req_v", mem_req_v, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_d_resp_v", d_resp_v, 0);
    chk("rst_i_resp_v", i_resp_v, 0);
    chk("rst_i_ready", i_ready, 0);

    // sw 0x100
    step(); drive_d(1'b1, 32'h100, 32'hDEADBEEF, 4'hF); settle();
    chk("sw_d_ready", d_ready, 1);
    chk("sw_i_ready", i_ready, 0);
    step(); d_req_v = 1'b0; mem_ready = 1'b1; settle();
    chk("sw_mem_req_v", mem_req_v, 1);
    chk("sw_mem_we", mem_we, 1);
    chk("sw_mem_addr", mem_addr, 32'h100);
    chk("sw_mem_wmask", mem_wmask, 4'hF);
    chk("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sw_ready_busy", d_ready, 0);
    step(); mem_ready = 1'b0; mem_resp_v = 1'b1; settle();
    chk("sw_d_resp_v", d_resp_v, 1);
    chk("sw_d_err", d_err, 0);
    chk("sw_i_resp_v", i_resp_v, 0);
    step(); mem_resp_v = 1'b0; settle();
    chk("sw_resp_once", d_resp_v, 0);
    chk("sw_req_dropped", mem_req_v, 0);

    // sb 0x203 with one stall cycle
    drive_d(1'b1, 32'h203, 32'h000000A5, 4'h1); settle();
    chk("sb_d_ready", d_ready, 1);
    step(); d_req_v = 1'b0; settle();
    chk("sb_mem_addr", mem_addr, 32'h200);
    chk("sb_mem_wmask", mem_wmask, 4'h8);
    chk("sb_mem_wdata", mem_wdata, 32'hA5000000);
    step(); mem_ready = 1'b1; settle();
    chk("sb_stall_req_v", mem_req_v, 1);
    chk("sb_stall_wdata", mem_wdata, 32'hA5000000);
    step(); mem_ready = 1'b0; mem_resp_v = 1'b1; settle();
    chk("sb_d_resp_v", d_resp_v, 1);
    step(); mem_resp_v = 1'b0; settle();

    // lh 0x302
    drive_d(1'b0, 32'h302, 32'h0, 4'h3); settle();
    chk("lh_d_ready", d_ready, 1);
    step(); d_req_v = 1'b0; mem_ready = 1'b1; settle();
    chk("lh_mem_we", mem_we, 0);
    chk("lh_mem_addr", mem_addr, 32'h300);
    chk("lh_mem_wmask", mem_wmask, 4'hC);
    step(); mem_ready = 1'b0; mem_resp_v = 1'b1; mem_rdata = 32'h80011234; settle();
    chk("lh_d_resp_v", d_resp_v, 1);
    chk("lh_d_rdata", d_rdata, 32'h00008001);
    chk("lh_d_err", d_err, 0);
    step(); mem_resp_v = 1'b0; settle();

    // fetch 0x40
    i_req_v = 1'b1; i_addr = 32'h40; settle();
    chk("if_i_ready", i_ready, 1);
    step(); i_req_v = 1'b0; mem_ready = 1'b1; settle();
    chk("if_mem_addr", mem_addr, 32'h40);
    chk("if_mem_we", mem_we, 0);
    chk("if_mem_wmask", mem_wmask, 0);
    step(); mem_ready = 1'b0; mem_resp_v = 1'b1; mem_rdata = 32'h12345678; settle();
    chk("if_i_resp_v", i_resp_v, 1);
    chk("if_i_rdata", i_rdata, 32'h12345678);
    chk("if_d_resp_v", d_resp_v, 0);

    // Both ports requesting every arbitration
    for (int k = 0; k < 4; k++) begin
      step(); mem_resp_v = 1'b0;
      i_req_v = 1'b1; i_addr = 32'h1000 + 32'(k * 4);
      drive_d(1'b1, 32'h2000 + 32'(k * 4), 32'(k), 4'hF); settle();
`ifdef RVGA_ARB_ROUND_ROBIN_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      chk("arb_d_ready", d_ready, exp_d);
      chk("arb_i_ready", i_ready, !exp_d);
      step(); if (exp_d) d_req_v = 1'b0; else i_req_v = 1'b0;
      mem_ready = 1'b1; settle();
      chk("arb_mem_we", mem_we, exp_d);
      chk("arb_no_ready", d_ready | i_ready, 0);
      step(); mem_ready = 1'b0; mem_resp_v = 1'b1; settle();
      chk("arb_d_resp_v", d_resp_v, exp_d);
      chk("arb_i_resp_v", i_resp_v, !exp_d);
    end
    step(); mem_resp_v = 1'b0; i_req_v = 1'b0; d_req_v = 1'b0; settle();
    chk("arb_idle", mem_req_v, 0);

    // Misaligned sh at 0x403
    step(); drive_d(1'b1, 32'h403, 32'h0000BEEF, 4'h3); settle();
    chk("mis_d_ready", d_ready, 1);
    step(); d_req_v = 1'b0; settle();
    chk("mis_mem_req_v", mem_req_v, 0);
    chk("mis_d_resp_v", d_resp_v, 1);
    chk("mis_d_err", d_err, 1);
    chk("mis_d_rdata", d_rdata, 0);
    step(); settle();
    chk("mis_resp_once", d_resp_v, 0);
    chk("mis_no_req", mem_req_v, 0);

    // Misaligned lw at 0x102
    drive_d(1'b0, 32'h102, 32'h0, 4'hF); settle();
    chk("mislw_d_ready", d_ready, 1);
    step(); d_req_v = 1'b0; settle();
    chk("mislw_d_err", d_err, 1);
    chk("mislw_mem_req_v", mem_req_v, 0);
    step(); settle();

    // Fetch timeout
    i_req_v = 1'b1; i_addr = 32'h80; mem_rdata = 32'hCAFEF00D; settle();
    chk("to_i_ready", i_ready, 1);
    step(); i_req_v = 1'b0; mem_ready = 1'b1; settle();
    chk("to_mem_req_v", mem_req_v, 1);
    step(); mem_ready = 1'b0; settle();
    for (int c = 0; c < 4; c++) begin
      chk("to_no_resp", i_resp_v, 0);
      step(); settle();
    end
    chk("to_i_resp_v", i_resp_v, 1);
    chk("to_i_err", i_err, 1);
    chk("to_i_rdata", i_rdata, 0);
    step(); mem_resp_v = 1'b1; settle();
    chk("to_late_i", i_resp_v, 0);
    chk("to_late_d", d_resp_v, 0);
    step(); mem_resp_v = 1'b0; settle();

    // Reset while waiting
    drive_d(1'b0, 32'h10, 32'h0, 4'hF); settle();
    step(); d_req_v = 1'b0; mem_ready = 1'b1; settle();
    step(); mem_ready = 1'b0; reset_n = 1'b0; mem_resp_v = 1'b1; settle();
    chk("rstmid_d_resp_v", d_resp_v, 0);
    step(); reset_n = 1'b1; mem_resp_v = 1'b0; settle();
    chk("rstmid_mem_req_v", mem_req_v, 0);
    chk("rstmid_d_resp_v2", d_resp_v, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
